// File: rtl/sprite_attr_ram.sv
// Single-clock sprite attribute RAM with byte-enable writes, write-first read forwarding and a
// hardware clear sweep. Define SPRITE_ATTR_RAM_RD_PIPE_EN to add an output register (latency 2).
`timescale 1ns/1ps

module sprite_attr_ram #(
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       ADDR_W  = 8,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  output logic                busy_o,
  input  logic                wr_en_i,
  input  logic [DATA_W/8-1:0] ben_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic                rd_en_i,
  input  logic [ADDR_W-1:0]   rd_addr_i,
  output logic [DATA_W-1:0]   rd_data_o,
  output logic                rd_valid_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned NB    = DATA_W / 8;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StClear = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              clearing;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] wr_merged;
  logic [DATA_W-1:0] rd_word;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  assign clearing = (state_q == StClear);
  assign busy_o   = clearing;
  assign wr_acc   = wr_en_i & ~clearing;
  assign rd_acc   = rd_en_i & ~clearing;

  // A restart request wins over sweep completion.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == StClear) begin
      if (clr_i) begin
        clr_cnt_d = '0;
      end else begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (&clr_cnt_q) begin
          state_d = StIdle;
        end
      end
    end else if (clr_i) begin
      state_d   = StClear;
      clr_cnt_d = '0;
    end
  end

  always_comb begin
    wr_merged = mem_q[wr_addr_i];
    for (int unsigned b = 0; b < NB; b++) begin
      if (ben_i[b]) begin
        wr_merged[8*b +: 8] = wr_data_i[8*b +: 8];
      end
    end
  end

  // Write-first: a same-address read sees the byte-merged word being written.
  always_comb begin
    if (wr_acc && (rd_addr_i == wr_addr_i)) begin
      rd_word = wr_merged;
    end else begin
      rd_word = mem_q[rd_addr_i];
    end
  end

  always_comb begin
    mem_we    = clearing | (wr_acc & (|ben_i));
    mem_waddr = clearing ? clr_cnt_q : wr_addr_i;
    mem_wdata = clearing ? CLR_VAL : wr_merged;
  end

  always_comb begin
    rd_valid_d = rd_acc;
    rd_data_d  = rd_acc ? rd_word : rd_data_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StClear;
      clr_cnt_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

`ifdef SPRITE_ATTR_RAM_RD_PIPE_EN
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  always_comb begin
    out_valid_d = rd_valid_q;
    out_data_d  = rd_valid_q ? rd_data_q : out_data_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign rd_valid_o = out_valid_q;
  assign rd_data_o  = out_data_q;
`else
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
`endif

endmodule

// File: tb/tb_sprite_attr_ram.sv
// Directed bench for sprite_attr_ram: reference model plus read scoreboard checked on negedge.
`timescale 1ns/1ps

module tb_sprite_attr_ram;

`ifdef SPRITE_ATTR_RAM_RD_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam logic [31:0] CLR2 = 32'hA5A5_0100;

  logic        clk_i = 1'b0;
  logic        rst_i, clr_i, wr_en_i, rd_en_i;
  logic [3:0]  ben_i;
  logic [7:0]  wr_addr_i, rd_addr_i;
  logic [31:0] wr_data_i;
  logic        busy_o, rd_valid_o, busy2, rd_valid2;
  logic [31:0] rd_data_o, rd_data2;

  sprite_attr_ram #(.DATA_W(32), .ADDR_W(8), .CLR_VAL(32'h0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .busy_o(busy_o), .wr_en_i(wr_en_i),
    .ben_i(ben_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .rd_en_i(rd_en_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o)
  );

  sprite_attr_ram #(.DATA_W(32), .ADDR_W(8), .CLR_VAL(CLR2)) dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .busy_o(busy2), .wr_en_i(wr_en_i),
    .ben_i(ben_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .rd_en_i(rd_en_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data2), .rd_valid_o(rd_valid2)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    logic [31:0] d2;
    bit          chk2;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [256];
  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] last_d = 32'h0;
  bit          chk2_on = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every valid pulse pops one expected read and must land on its due cycle.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i) begin
      last_d = 32'h0;
    end else if (rd_valid_o) begin
      if (sb.size() == 0) begin
        check("spurious_valid", {31'b0, rd_valid_o}, 32'h0);
      end else begin
        e = sb.pop_front();
        check("rd_due_cycle", cyc, e.due);
        check("rd_data", rd_data_o, e.d);
        if (e.chk2) begin
          check("rd_valid_clrval", {31'b0, rd_valid2}, 32'h1);
          check("rd_data_clrval", rd_data2, e.d2);
        end
      end
      last_d = rd_data_o;
    end else begin
      check("rd_hold", rd_data_o, last_d);
      if (sb.size() != 0 && sb[0].due < cyc) begin
        check("missing_valid", {31'b0, rd_valid_o}, 32'h1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic op(input bit we, input logic [3:0] be, input logic [7:0] wa,
                    input logic [31:0] wd, input bit re, input logic [7:0] ra, input bit acc);
    logic [31:0] merged;
    exp_t        e;
    wr_en_i = we; ben_i = be; wr_addr_i = wa; wr_data_i = wd;
    rd_en_i = re; rd_addr_i = ra;
    if (acc) begin
      merged = model[wa];
      for (int b = 0; b < 4; b++) if (be[b]) merged[8*b +: 8] = wd[8*b +: 8];
      if (re) begin
        e.d    = (we && ra == wa) ? merged : model[ra];
        e.d2   = CLR2;
        e.chk2 = chk2_on;
        e.due  = cyc + LAT;
        sb.push_back(e);
      end
      if (we) model[wa] = merged;
    end
    tick();
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int exp_n);
    int n = 0;
    while (busy_o && n < 2000) begin
      tick();
      n++;
    end
    check(tag, n, exp_n);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model[i] = 32'h0;
  endtask

  initial begin
    rst_i = 1'b1; clr_i = 1'b0; wr_en_i = 1'b0; rd_en_i = 1'b0;
    ben_i = 4'h0; wr_addr_i = 8'h0; rd_addr_i = 8'h0; wr_data_i = 32'h0;
    model_clear();

    // Reset and initial clear sweep
    tick(); tick();
    check("reset_busy", {31'b0, busy_o}, 32'h1);
    check("reset_valid", {31'b0, rd_valid_o}, 32'h0);
    check("reset_data", rd_data_o, 32'h0);
    rst_i = 1'b0;
    wait_idle("reset_sweep_len", 256);
    check("busy_clrval_inst", {31'b0, busy2}, 32'h0);
    chk2_on = 1'b1;
    op(0, 4'h0, 8'h00, 32'h0, 1, 8'h00, 1);
    op(0, 4'h0, 8'h00, 32'h0, 1, 8'h7F, 1);
    op(0, 4'h0, 8'h00, 32'h0, 1, 8'hFF, 1);
    chk2_on = 1'b0;
    repeat (3) tick();

    // Byte-enable writes, including an all-zero enable
    op(1, 4'hF, 8'h10, 32'h1122_3344, 0, 8'h00, 1);
    op(1, 4'b0101, 8'h10, 32'hAABB_CCDD, 0, 8'h00, 1);
    op(0, 4'h0, 8'h00, 32'h0, 1, 8'h10, 1);
    op(1, 4'h0, 8'h10, 32'hFFFF_FFFF, 0, 8'h00, 1);
    op(0, 4'h0, 8'h00, 32'h0, 1, 8'h10, 1);

    // Same-cycle read/write collisions
    op(1, 4'hF, 8'h20, 32'h0102_0304, 0, 8'h00, 1);
    op(1, 4'hF, 8'h21, 32'h5566_7788, 0, 8'h00, 1);
    op(1, 4'b1000, 8'h20, 32'hF0F0_F0F0, 1, 8'h20, 1);
    op(1, 4'b0011, 8'h20, 32'h1234_5678, 1, 8'h21, 1);
    op(0, 4'h0, 8'h00, 32'h0, 1, 8'h20, 1);
    repeat (3) tick();

    // Clear from idle: same-cycle ops accepted, ops during sweep dropped
    clr_i = 1'b1;
    op(1, 4'hF, 8'h30, 32'hCAFE_BABE, 1, 8'h30, 1);
    clr_i = 1'b0;
    model_clear();
    check("busy_after_clr", {31'b0, busy_o}, 32'h1);
    repeat (3) op(1, 4'hF, 8'h05, 32'h0000_DEAD, 1, 8'h05, 0);
    wait_idle("clr_sweep_len", 253);
    op(0, 4'h0, 8'h00, 32'h0, 1, 8'h05, 1);
    op(0, 4'h0, 8'h00, 32'h0, 1, 8'h30, 1);
    repeat (3) tick();

    // Restart by clr_i at clr_cnt=100
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    repeat (100) tick();
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    check("busy_after_restart", {31'b0, busy_o}, 32'h1);
    wait_idle("clr_restart_len", 256);

    // Restart by rst_i at clr_cnt=100
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    repeat (100) tick();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    wait_idle("rst_restart_len", 256);

    // Streaming reads
    for (int i = 0; i < 256; i++) op(1, 4'hF, 8'(i), 32'(i), 0, 8'h00, 1);
    for (int i = 0; i < 256; i++) op(0, 4'h0, 8'h00, 32'h0, 1, 8'(i), 1);
    repeat (4) tick();
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
